dpwm_sequencer: RTL and testbench
=================================

Name: dpwm_sequencer

Overview:
Controller that sequences the dithered DPWM path for the digital buck converter. Generates the switching-period and dither-frame timing as single-cycle strobes on clk, replacing the divided ripple clock. Accepts 9-bit duty commands from the compensator through a valid/ready handshake and applies soft-start, clamping and fault shutdown. Emits the per-period 6-bit integer duty consumed by the counter DPWM.

Parameters:
CNT_W, 6, DPWM counter width; switching period = 2^CNT_W clk cycles.
FRAC_W, 3, dither fraction bits; frame = 2^FRAC_W periods.
DMAX, 60, max integer duty code; must be ≤ 2^CNT_W−2.
SS_STEP_PERIODS, 4, periods per +1 fractional LSB of the soft-start ramp.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
en  in  1  converter enable, level
fault  in  1  overcurrent/overvoltage fault, level
cmd_valid  in  1  compensator command valid
cmd_ready  out  1  sequencer can accept a command
cmd_duty  in  CNT_W+FRAC_W  duty command (integer.fraction)
period_start  out  1  one-cycle pulse, first cycle of each period
frame_done  out  1  one-cycle pulse, last cycle of the last period in a frame
duty_int  out  CNT_W  integer duty for the current period, to the counter DPWM
dither_phase  out  FRAC_W  period index within the frame
pwm_en  out  1  gate-drive enable
state  out  2  IDLE=0, SOFTSTART=1, RUN=2, FAULT=3

Behaviour:
- Reset: state IDLE. All outputs 0. pcnt, dph, ss, tgt and pend are cleared.
- pcnt (CNT_W bits) increments every clk in SOFTSTART and RUN. It is held at 0 in IDLE and FAULT.
- period_start is high exactly in cycles where pcnt==0 and state is SOFTSTART or RUN.
- dph increments on each period_start after the first; it wraps at 2^FRAC_W.
- frame_done is high when pcnt==2^CNT_W−1 and dph==2^FRAC_W−1.
- Frame boundary is the cycle after frame_done.
- Handshake:
  - cmd_ready = (state∈{SOFTSTART,RUN}) && !pend_valid.
  - Transfer occurs on cmd_valid&&cmd_ready; the command is stored in pend and pend_valid is set.
  - At frame boundary, if pend_valid: tgt ← min(pend, {DMAX,FRAC_W'b0}) and pend_valid clears.
  - A command accepted in the same cycle as frame_done is applied at the following frame boundary.
- Effective duty eff:
  - SOFTSTART: eff = min(ss, tgt).
  - RUN: eff = tgt.
- ss increments by 1 every SS_STEP_PERIODS periods in SOFTSTART and saturates at its maximum value.
- Dither:
  - duty_int = eff[MSBs] + ((bitrev(dph) < eff[FRAC_W−1:0]) ? 1 : 0).
  - eff is sampled only at period boundaries, so duty_int is constant across the whole period.
  - duty_int and dither_phase register on the edge that begins the period, so they are valid in the period_start cycle.
- FSM:
  - IDLE → SOFTSTART when en=1 and fault=0. Next cycle: pwm_en=1, period_start=1, dph=0, ss=0.
  - SOFTSTART → RUN at a frame boundary where ss ≥ tgt and tgt has been loaded at least once.
  - SOFTSTART/RUN → IDLE on en=0, taking effect at the next period_start. The current period completes; then pwm_en=0 and duty_int=0.
  - Any state → FAULT when fault=1 (highest priority, no period alignment). Next cycle: pwm_en=0, duty_int=0, cmd_ready=0, pend discarded.
  - FAULT → IDLE only when fault=0 and en=0.
- Entering IDLE clears pend_valid, tgt and ss.
- Async reset mid-period forces reset values immediately.

Decomposition:
- Package dpwm_pkg: CNT_W/FRAC_W defaults, state encoding constants, bitrev function.
- Sub-module dither_slot_sel: combinational bitrev compare plus increment. Inputs eff and dph; output duty_int. It is reused by the existing dither DPWM.

Test Plan:
- Reset asserted mid-RUN → all outputs 0 within the same cycle, state=0; counters restart from 0 after en.
- SS_STEP_PERIODS=1, en=1, cmd_duty=200 → duty_int ramps 0..25 over 200 periods, then state=RUN at period 200 (a frame boundary). duty_int=25 in every subsequent period.
- RUN, cmd_duty=203 → per frame, duty_int sequence is 26,25,26,25,26,25,25,25 (sum 203). dither_phase counts 0..7, and frame_done fires every 512 clk.
- cmd_duty=511 with DMAX=60 → duty_int=60 in all periods, no increment.
- Command accepted at dph=3 → applied at next dph=0. A second cmd_valid before then → cmd_ready=0, no transfer, no loss of the first command.
- fault=1 at pcnt=17 → next cycle pwm_en=0, duty_int=0, state=3. en=0 with fault=1 stays in FAULT; fault=0 and en=0 → IDLE.

Source files
------------

// File: rtl/dpwm_pkg.sv
// -----------------------------------------------------------------------------
// dpwm_pkg
// Shared definitions for the dithered DPWM path: default counter/fraction
// widths, the sequencer state encoding and the bit-reversal helper that
// spreads the dither slots evenly across a frame.
// -----------------------------------------------------------------------------
package dpwm_pkg;

  localparam int CNT_W_DEF  = 6;   // DPWM counter width
  localparam int FRAC_W_DEF = 3;   // dither fraction bits
  localparam int BITREV_MAX = 16;  // widest field bitrev() handles

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SOFTSTART = 2'd1,
    ST_RUN       = 2'd2,
    ST_FAULT     = 2'd3
  } state_e;

  // Reverse the low w bits of v; bits above w in the result are zero.
  // The full field is reversed, then shifted down so the w-bit reversal
  // lands in the LSBs.
  function automatic logic [BITREV_MAX-1:0] bitrev(input logic [BITREV_MAX-1:0] v,
                                                   input int                    w);
    logic [BITREV_MAX-1:0] r;
    r = {<<{v}};
    return r >> (BITREV_MAX - w);
  endfunction

endpackage

// File: rtl/dither_slot_sel.sv
// -----------------------------------------------------------------------------
// dither_slot_sel
// Picks the integer duty for one period of a dither frame. A period gets one
// extra count when the bit-reversed period index is below the fractional part
// of the duty, so the extra counts are spread evenly over the frame.
//
// Ports:
//   eff      in  CNT_W+FRAC_W  effective duty (integer.fraction)
//   dph      in  FRAC_W        period index within the frame
//   duty_int out CNT_W         integer duty for this period
// -----------------------------------------------------------------------------
module dither_slot_sel
  import dpwm_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic [CNT_W+FRAC_W-1:0] eff,
  input  logic [FRAC_W-1:0]       dph,
  output logic [CNT_W-1:0]        duty_int
);

  logic [FRAC_W-1:0] slot_rank;
  logic              bump;

  assign slot_rank = FRAC_W'(bitrev(BITREV_MAX'(dph), FRAC_W));
  assign bump      = (slot_rank < eff[FRAC_W-1:0]);
  assign duty_int  = eff[CNT_W+FRAC_W-1:FRAC_W] + {{(CNT_W-1){1'b0}}, bump};

endmodule

// File: rtl/dpwm_sequencer.sv
// -----------------------------------------------------------------------------
// dpwm_sequencer
// Sequences the dithered DPWM: generates period/frame strobes, takes duty
// commands over valid/ready, applies them at frame boundaries with clamping,
// ramps the duty during soft-start and shuts down immediately on fault.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   en                converter enable (level)
//   fault             fault input (level), highest priority
//   cmd_valid/ready   duty command handshake
//   cmd_duty          duty command, CNT_W integer + FRAC_W fraction bits
//   period_start      pulse, first cycle of each switching period
//   frame_done        pulse, last cycle of the last period of a frame
//   duty_int          integer duty for the current period
//   dither_phase      period index within the frame
//   pwm_en            gate-drive enable
//   state             IDLE=0, SOFTSTART=1, RUN=2, FAULT=3
// -----------------------------------------------------------------------------
module dpwm_sequencer
  import dpwm_pkg::*;
#(
  parameter int CNT_W           = CNT_W_DEF,
  parameter int FRAC_W          = FRAC_W_DEF,
  parameter int DMAX            = 60,
  parameter int SS_STEP_PERIODS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    fault,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [CNT_W+FRAC_W-1:0] cmd_duty,
  output logic                    period_start,
  output logic                    frame_done,
  output logic [CNT_W-1:0]        duty_int,
  output logic [FRAC_W-1:0]       dither_phase,
  output logic                    pwm_en,
  output logic [1:0]              state
);

  localparam int DW    = CNT_W + FRAC_W;
  localparam int SSC_W = (SS_STEP_PERIODS > 1) ? $clog2(SS_STEP_PERIODS) : 1;

  localparam logic [DW-1:0]    DUTY_CLAMP = DW'(DMAX * (2 ** FRAC_W));
  localparam logic [SSC_W-1:0] SSC_LAST   = SSC_W'(SS_STEP_PERIODS - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  pcnt_q, pcnt_d;
  logic [FRAC_W-1:0] dph_q, dph_d;
  logic [DW-1:0]     ss_q, ss_d;
  logic [SSC_W-1:0]  ssc_q, ssc_d;
  logic [DW-1:0]     tgt_q, tgt_d;
  logic              tgt_loaded_q, tgt_loaded_d;
  logic [DW-1:0]     pend_q, pend_d;
  logic              pend_valid_q, pend_valid_d;
  logic [CNT_W-1:0]  duty_q;

  logic              active, active_d;
  logic              period_end, frame_end, period_begin;
  logic              accept;
  logic [DW-1:0]     eff_d;
  logic [CNT_W-1:0]  slot_duty;

  assign active     = (state_q == ST_SOFTSTART) || (state_q == ST_RUN);
  assign period_end = active && (pcnt_q == '1);
  assign frame_end  = period_end && (dph_q == '1);
  assign accept     = cmd_valid && cmd_ready;

  // Datapath advance: the values the counters and command registers take if
  // the converter stays active. Clearing on IDLE/FAULT is applied at the flops.
  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    pcnt_d       = active ? pcnt_q + CNT_W'(1) : '0;
    dph_d        = dph_q;
    ss_d         = ss_q;
    ssc_d        = ssc_q;
    tgt_d        = tgt_q;
    tgt_loaded_d = tgt_loaded_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;

    if (period_end) begin
      dph_d = dph_q + FRAC_W'(1);
    end

    if (period_end && (state_q == ST_SOFTSTART)) begin
      if (ssc_q == SSC_LAST) begin
        ssc_d = '0;
        if (ss_q != '1) begin
          ss_d = ss_q + DW'(1);
        end
      end else begin
        ssc_d = ssc_q + SSC_W'(1);
      end
    end

    // A pending command takes effect for the whole next frame. A command
    // accepted during frame_done is not yet in pend here, so it waits a frame.
    if (frame_end && pend_valid_q) begin
      tgt_d        = (pend_q < DUTY_CLAMP) ? pend_q : DUTY_CLAMP;
      tgt_loaded_d = 1'b1;
      pend_valid_d = 1'b0;
    end

    if (accept) begin
      pend_d       = cmd_duty;
      pend_valid_d = 1'b1;
    end
  end

  // Next-state logic. The soft-start exit looks at the ramp and target values
  // that will be in force for the new frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_SOFTSTART;
      end
      ST_SOFTSTART: begin
        if (period_end && !en) begin
          state_d = ST_IDLE;
        end else if (frame_end && tgt_loaded_d && (ss_d >= tgt_d)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (period_end && !en) state_d = ST_IDLE;
      end
      ST_FAULT: begin
        if (!en) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (fault) state_d = ST_FAULT;
  end

  assign active_d     = (state_d == ST_SOFTSTART) || (state_d == ST_RUN);
  assign period_begin = active_d && (pcnt_d == '0);
  assign eff_d        = (state_d == ST_SOFTSTART && ss_d < tgt_d) ? ss_d : tgt_d;

  dither_slot_sel #(
    .CNT_W  (CNT_W),
    .FRAC_W (FRAC_W)
  ) u_slot_sel (
    .eff      (eff_d),
    .dph      (dph_d),
    .duty_int (slot_duty)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Datapath registers. Leaving the active states wipes everything, so IDLE
  // and FAULT both restart from a clean ramp with no stale command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || !active_d) begin
      pcnt_q       <= '0;
      dph_q        <= '0;
      ss_q         <= '0;
      ssc_q        <= '0;
      tgt_q        <= '0;
      tgt_loaded_q <= 1'b0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      duty_q       <= '0;
    end else begin
      pcnt_q       <= pcnt_d;
      dph_q        <= dph_d;
      ss_q         <= ss_d;
      ssc_q        <= ssc_d;
      tgt_q        <= tgt_d;
      tgt_loaded_q <= tgt_loaded_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      // Duty is latched only on the edge that opens a period, so it is valid
      // in the period_start cycle and constant for the whole period.
      if (period_begin) duty_q <= slot_duty;
    end
  end

  // Outputs decoded from registered state.
  always_comb begin
    period_start = active && (pcnt_q == '0);
    frame_done   = frame_end;
    cmd_ready    = active && !pend_valid_q;
    pwm_en       = active;
    duty_int     = duty_q;
    dither_phase = dph_q;
    state        = state_q;
  end

endmodule

// File: tb/tb_dpwm_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dpwm_sequencer
// Directed bench for dpwm_sequencer with a one-period soft-start step.
// Outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_dpwm_sequencer;

  logic       clk = 1'b0;
  logic       rst, en, fault, cmd_valid;
  logic [8:0] cmd_duty;
  logic       cmd_ready, period_start, frame_done, pwm_en;
  logic [5:0] duty_int;
  logic [2:0] dither_phase;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;
  int n;
  int exp_seq [8] = '{26, 25, 26, 25, 26, 25, 25, 25};

  dpwm_sequencer #(
    .CNT_W           (6),
    .FRAC_W          (3),
    .DMAX            (60),
    .SS_STEP_PERIODS (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .fault        (fault),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_duty     (cmd_duty),
    .period_start (period_start),
    .frame_done   (frame_done),
    .duty_int     (duty_int),
    .dither_phase (dither_phase),
    .pwm_en       (pwm_en),
    .state        (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    total++;
    assert (obs === 32'(exp)) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int c);
    repeat (c) @(negedge clk);
  endtask

  // Advance to the next period_start cycle, bounded.
  task automatic next_ps(input string tag);
    int w = 0;
    @(negedge clk);
    while (period_start !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) check({tag, "_timeout"}, 32'(period_start), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; fault = 1'b0; cmd_valid = 1'b0; cmd_duty = '0;

    // Reset state
    cycles(2);
    check("rst_state", 32'(state), 0);
    check("rst_pwm_en", 32'(pwm_en), 0);
    check("rst_period_start", 32'(period_start), 0);
    check("rst_duty", 32'(duty_int), 0);
    check("rst_cmd_ready", 32'(cmd_ready), 0);
    rst = 1'b0;
    cycles(2);
    check("idle_no_en", 32'(state), 0);

    // Soft-start ramp to 200 (25.0)
    cmd_duty = 9'd200; cmd_valid = 1'b1; en = 1'b1;
    next_ps("ss_entry");
    check("ss_state", 32'(state), 1);
    check("ss_pwm_en", 32'(pwm_en), 1);
    check("ss_duty0", 32'(duty_int), 0);
    check("ss_dph0", 32'(dither_phase), 0);
    check("ss_ready", 32'(cmd_ready), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("ss_pend_full", 32'(cmd_ready), 0);
    for (int k = 1; k <= 200; k++) begin
      next_ps("ramp");
      case (k)
        7:   check("ramp_p7", 32'(duty_int), 0);
        8:   check("ramp_p8", 32'(duty_int), 1);
        12:  check("ramp_p12", 32'(duty_int), 2);
        100: begin
          check("ramp_p100", 32'(duty_int), 13);
          check("ramp_p100_dph", 32'(dither_phase), 4);
          cycles(30);
          check("ramp_p100_hold", 32'(duty_int), 13);
        end
        199: begin
          check("ramp_p199", 32'(duty_int), 24);
          check("ramp_p199_state", 32'(state), 1);
        end
        200: begin
          check("run_p200", 32'(duty_int), 25);
          check("run_p200_state", 32'(state), 2);
          check("run_p200_dph", 32'(dither_phase), 0);
        end
        default: ;
      endcase
    end

    // Command accepted at dph=3, second command held off
    repeat (3) next_ps("to_dph3");
    check("dph3", 32'(dither_phase), 3);
    check("dph3_ready", 32'(cmd_ready), 1);
    cmd_duty = 9'd203; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_duty = 9'd511;
    check("second_blocked", 32'(cmd_ready), 0);
    repeat (4) next_ps("to_dph7");
    check("old_duty_dph7", 32'(duty_int), 25);
    check("dph7_blocked", 32'(cmd_ready), 0);
    cmd_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      next_ps("frame203");
      check("seq203_duty", 32'(duty_int), exp_seq[i]);
      check("seq203_dph", 32'(dither_phase), i);
    end

    // Frame strobe spacing
    n = 0;
    while (frame_done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("fd_first", 32'(frame_done), 1);
    @(negedge clk);
    check("boundary_ps", 32'(period_start), 1);
    check("boundary_dph", 32'(dither_phase), 0);
    n = 1;
    while (frame_done !== 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
    end
    check("fd_interval", 32'(n), 512);

    // Command accepted in the frame_done cycle waits one more frame
    check("fd_ready", 32'(cmd_ready), 1);
    cmd_duty = 9'd100; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("fd_cmd_not_yet", 32'(duty_int), 26);
    repeat (8) next_ps("to_fd_apply");
    check("fd_cmd_applied", 32'(duty_int), 13);

    // Clamp 511 to DMAX
    cmd_duty = 9'd511; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (8) next_ps("to_clamp");
    for (int i = 0; i < 8; i++) begin
      check("clamp_duty", 32'(duty_int), 60);
      if (i < 7) next_ps("clamp");
    end

    // Fault at pcnt=17
    next_ps("pre_fault");
    cycles(17);
    fault = 1'b1;
    @(negedge clk);
    check("fault_pwm_en", 32'(pwm_en), 0);
    check("fault_duty", 32'(duty_int), 0);
    check("fault_state", 32'(state), 3);
    check("fault_ready", 32'(cmd_ready), 0);
    en = 1'b0;
    cycles(3);
    check("fault_held", 32'(state), 3);
    fault = 1'b0; en = 1'b1;
    cycles(2);
    check("fault_en_high", 32'(state), 3);
    en = 1'b0;
    @(negedge clk);
    check("fault_exit", 32'(state), 0);

    // Graceful stop on en=0
    en = 1'b1; cmd_duty = 9'd16; cmd_valid = 1'b1;
    next_ps("restart");
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (16) next_ps("ramp16");
    check("run16_state", 32'(state), 2);
    check("run16_duty", 32'(duty_int), 2);
    cycles(5);
    en = 1'b0;
    cycles(58);
    check("stop_pending_state", 32'(state), 2);
    check("stop_pending_pwm", 32'(pwm_en), 1);
    @(negedge clk);
    check("stop_state", 32'(state), 0);
    check("stop_pwm", 32'(pwm_en), 0);
    check("stop_duty", 32'(duty_int), 0);

    // Asynchronous reset mid-period
    en = 1'b1; cmd_duty = 9'd16; cmd_valid = 1'b1;
    next_ps("pre_reset");
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (10) next_ps("pre_reset_run");
    check("p10_duty", 32'(duty_int), 1);
    cycles(7);
    #2 rst = 1'b1;
    #1;
    check("arst_state", 32'(state), 0);
    check("arst_pwm", 32'(pwm_en), 0);
    check("arst_dph", 32'(dither_phase), 0);
    check("arst_duty", 32'(duty_int), 0);
    check("arst_ready", 32'(cmd_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ps", 32'(period_start), 1);
    check("post_rst_state", 32'(state), 1);
    check("post_rst_dph", 32'(dither_phase), 0);
    check("post_rst_duty", 32'(duty_int), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
